scc_exec_sequencer: RTL
=======================

# scc_exec_sequencer

Multi-cycle control sequencer for the single-cycle-core execute datapath. It fetches an instruction word over a req/ack handshake and hands it to the decoder. It then strobes the EX unit, owns the architectural PC and CPSR (N,C,Z,V) registers, and evaluates branch conditions. It also gates register-file writeback. It sits between instruction memory, the decoder, the EX stage and the register file.

## Interface
- `PC_WIDTH`, default 32: width of the program counter (word-addressed).
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high; one clock, and reset is synchronous and active-high.
- `run`  in  1  starts sequencing from IDLE.
- `imem_req`  out  1  fetch request; reset 0.
- `imem_addr`  out  PC_WIDTH  fetch address, equal to `pc_q`; reset RESET_PC.
- `imem_ack`  in  1  fetch complete, with `imem_data` valid this cycle.
- `imem_data`  in  32  instruction word.
- `instr_q`  out  32  latched instruction, driven to the decoder; reset 0.
- `dec_first_ld`  in  2  first-level decode field.
- `dec_special`  in  1  ALU-class instruction.
- `dec_alu_oc`  in  3  operation code.
- `dec_set_flags`  in  1  second-level decode bit 3.
- `dec_b_cond`  in  4  branch condition code.
- `dec_offset`  in  16  signed branch offset, in words.
- `alu_flags`  in  4  N,C,Z,V produced by EX for the current op.
- `ex_valid`  out  1  one-cycle EX strobe; reset 0.
- `rf_we`  out  1  register-file write enable, one cycle; reset 0.
- `cpsr_q`  out  4  architectural N,C,Z,V; reset 0000.
- `pc_q`  out  PC_WIDTH  program counter; reset RESET_PC.
- `halted`  out  1  high in HALT; reset 0.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT. Reset state is IDLE.
- IDLE → FETCH when `run`=1.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`, latch `imem_data` into `instr_q` and go to DECODE.
  - Otherwise stay in FETCH with req held.
- DECODE: one cycle for the decoder to settle on `instr_q`; → EXECUTE.
- EXECUTE: `ex_valid`=1 for exactly one cycle; → WRITEBACK.
- WRITEBACK: commits exactly one of the following cases.
  - ALU op (`dec_special`=1):
    - `rf_we`=1.
    - If `dec_set_flags`, `cpsr_q` ← `alu_flags`.
    - PC ← PC+1.
  - Move/shift op (`dec_special`=0, `dec_first_ld`=00): `rf_we`=1, PC ← PC+1. CPSR unchanged.
  - Branch (`dec_special`=0, `dec_first_ld`=10):
    - If taken, PC ← PC + sign-extended `dec_offset`; otherwise PC ← PC+1.
    - `rf_we`=0.
  - Halt (`dec_special`=0, `dec_first_ld`=11, `dec_alu_oc`=111): → HALT with PC unchanged.
  - Any other encoding is a NOP: PC ← PC+1.
- After any non-halt commit, → FETCH. `run` is sampled only in IDLE.
- Condition table (taken when true):
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C.
  - 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 !(C&!Z).
  - 1010 N==V; 1011 N!=V.
  - 1100 !Z&(N==V); 1101 !(!Z&(N==V)).
  - 1110 always; 1111 never.
- Conditions evaluate against registered `cpsr_q`, never against `alu_flags`.
- PC arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- HALT: `halted`=1; only `rst` exits.

## Timing
- Minimum instruction period is 4 cycles (ack in first FETCH cycle). Each cycle of ack delay adds 1.
- `imem_ack` outside FETCH is ignored. `imem_data` is sampled only with ack.
- `ex_valid` and `rf_we` are registered single-cycle pulses, never overlapping.
- `cpsr_q` and `pc_q` change only on the WRITEBACK→next edge. A flag-setting op is visible to the immediately following branch.
- `rst` in any state, including mid-fetch with req high:
  - Next cycle is IDLE, with `imem_req`=0 and all outputs at reset values.
  - A pending ack is dropped.
- `rst` and `imem_ack` in the same cycle: reset wins.

## Structure
- Shared package `scc_pkg` holds:
  - state enum;
  - condition-code constants (EQ…NV);
  - first-level decode constants (ALU/MOV=00, BR=10, SYS=11);
  - HALT opcode 111;
  - flag bit indices N=3, C=2, Z=1, V=0.
- Sub-module `scc_cond_eval`: combinational, inputs cpsr[3:0] and cond[3:0], output `taken`.

## Test plan
- Reset with `RESET_PC`=0x10, `run`=1, ack in the same cycle → `imem_addr`=0x10; `ex_valid` 2 cycles after the ack cycle; `rf_we` 3 cycles after.
- ALU op with set_flags=1, `alu_flags`=0110 → `cpsr_q`=0110, PC 0x10→0x11. A following op with set_flags=0 and flags 1001 leaves `cpsr_q`=0110.
- `cpsr_q` Z=1, BEQ (0000) with offset 0xFFFC at PC 0x20 → PC=0x1C, `rf_we`=0. Then BNE with offset 0x0005 → not taken, PC=0x1D.
- Ack delayed 3 cycles → `imem_req` held 4 cycles and `instr_q` updated only on the ack edge. A spurious ack in EXECUTE is ignored.
- PC=0xFFFFFFFF with a NOP → PC wraps to 0. HALT encoding → `halted`=1, PC unchanged, no further `imem_req`.
- `rst` asserted mid-FETCH with ack in the same cycle → IDLE; `instr_q`=0, `pc_q`=RESET_PC, `cpsr_q`=0000.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared definitions for the execute sequencer: FSM states, branch condition
// codes, first-level decode classes, the HALT opcode and CPSR bit positions.
// Pure declarations; no logic, no latency, no flow control.
package scc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Branch condition codes
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // First-level decode classes (ALU ops share 00 with MOV, split by dec_special)
  localparam logic [1:0] FL_MOV = 2'b00;
  localparam logic [1:0] FL_BR  = 2'b10;
  localparam logic [1:0] FL_SYS = 2'b11;

  localparam logic [2:0] OC_HALT = 3'b111;

  // CPSR bit positions
  localparam int FLAG_N = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/scc_exec_sequencer_if.sv
// Instruction-memory fetch port: req/addr from the sequencer, ack/data back.
// Latency: memory may take any number of cycles; data is valid only with ack.
// Backpressure: req is held until ack, no outstanding-request limit beyond one.
interface scc_exec_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_data
  );
endinterface

// File: rtl/scc_cond_eval.sv
// Branch condition evaluator: cpsr[3:0] (N,C,Z,V) and cond[3:0] -> taken.
// Latency: purely combinational.
// Backpressure: none.
module scc_cond_eval
  import scc_pkg::*;
(
  input  logic [3:0] cpsr,
  input  logic [3:0] cond,
  output logic       taken
);

  logic n, c, z, v;

  assign n = cpsr[FLAG_N];
  assign c = cpsr[FLAG_C];
  assign z = cpsr[FLAG_Z];
  assign v = cpsr[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_CS: taken = c;
      COND_CC: taken = !c;
      COND_MI: taken = n;
      COND_PL: taken = !n;
      COND_VS: taken = v;
      COND_VC: taken = !v;
      COND_HI: taken = c && !z;
      COND_LS: taken = !(c && !z);
      COND_GE: taken = (n == v);
      COND_LT: taken = (n != v);
      COND_GT: taken = !z && (n == v);
      COND_LE: taken = !(!z && (n == v));
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/scc_exec_sequencer.sv
// Multi-cycle execute sequencer: fetch -> decode -> execute -> writeback; owns
// PC and CPSR, evaluates branches, gates register-file writes, halts on HALT.
// Latency: 4 cycles per instruction plus memory ack delay; fetch stalls on ack.
// Ports: clk/rst, run; imem (master fetch port); instr_q to decoder; dec_* and
// alu_flags from decoder/EX; ex_valid, rf_we strobes; cpsr_q, pc_q, halted.
module scc_exec_sequencer
  import scc_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  scc_exec_sequencer_if.master imem,
  output logic [31:0]          instr_q,
  input  logic [1:0]           dec_first_ld,
  input  logic                 dec_special,
  input  logic [2:0]           dec_alu_oc,
  input  logic                 dec_set_flags,
  input  logic [3:0]           dec_b_cond,
  input  logic [15:0]          dec_offset,
  input  logic [3:0]           alu_flags,
  output logic                 ex_valid,
  output logic                 rf_we,
  output logic [3:0]           cpsr_q,
  output logic [PC_WIDTH-1:0]  pc_q,
  output logic                 halted
);

  state_e              state_q;
  logic                br_taken;
  logic                is_halt;
  logic                is_branch;
  logic                writes_rf;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_br;

  // Branches test the registered CPSR, so a flag-setting op committed on the
  // previous writeback edge is already visible here.
  scc_cond_eval u_cond (
    .cpsr  (cpsr_q),
    .cond  (dec_b_cond),
    .taken (br_taken)
  );

  assign is_halt   = !dec_special && (dec_first_ld == FL_SYS) && (dec_alu_oc == OC_HALT);
  assign is_branch = !dec_special && (dec_first_ld == FL_BR);
  assign writes_rf = dec_special || (dec_first_ld == FL_MOV);

  // Size cast of a signed operand sign-extends the word offset; the add wraps.
  assign pc_inc = pc_q + PC_WIDTH'(1);
  assign pc_br  = pc_q + PC_WIDTH'($signed(dec_offset));

  assign imem.imem_addr = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      imem.imem_req <= 1'b0;
      instr_q       <= '0;
      ex_valid      <= 1'b0;
      rf_we         <= 1'b0;
      cpsr_q        <= '0;
      pc_q          <= RESET_PC;
      halted        <= 1'b0;
    end else begin
      ex_valid <= 1'b0;
      rf_we    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run) begin
            state_q       <= ST_FETCH;
            imem.imem_req <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (imem.imem_ack) begin
            instr_q       <= imem.imem_data;
            imem.imem_req <= 1'b0;
            state_q       <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          state_q  <= ST_EXECUTE;
          ex_valid <= 1'b1;
        end
        ST_EXECUTE: begin
          // The decoder has been stable on instr_q since DECODE, so the write
          // enable can be registered here and line up with the WRITEBACK cycle.
          state_q <= ST_WRITEBACK;
          rf_we   <= writes_rf;
        end
        ST_WRITEBACK: begin
          if (is_halt) begin
            state_q <= ST_HALT;
            halted  <= 1'b1;
          end else begin
            state_q       <= ST_FETCH;
            imem.imem_req <= 1'b1;
            pc_q          <= (is_branch && br_taken) ? pc_br : pc_inc;
            if (dec_special && dec_set_flags) begin
              cpsr_q <= alu_flags;
            end
          end
        end
        ST_HALT: begin
          state_q <= ST_HALT;
        end
        default: begin
          state_q       <= ST_IDLE;
          imem.imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
